// File: rtl/demux32_1x2_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : demux32_1x2_reg_if
// Purpose  : Producer-side and consumer-side handshake bundle for the
//            registered 1-to-2 word demultiplexer.
// Revision : 1.0  initial release
// ============================================================================
interface demux32_1x2_reg_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i;
  logic                  s;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] y0;
  logic [DATA_WIDTH-1:0] y1;
  logic                  y0_valid;
  logic                  y1_valid;
  logic                  y0_ready;
  logic                  y1_ready;

  modport master (
    output i, s, in_valid, y0_ready, y1_ready,
    input  in_ready, y0, y1, y0_valid, y1_valid
  );

  modport slave (
    input  i, s, in_valid, y0_ready, y1_ready,
    output in_ready, y0, y1, y0_valid, y1_valid
  );
endinterface
`default_nettype wire

// File: rtl/demux32_1x2_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux32_1x2_reg
// Purpose  : Registered 1-to-2 demultiplexer with a one-word holding slot and
//            valid/ready handshake per output. Optional per-port transfer
//            counters when DEMUX32_STATS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module demux32_1x2_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  wire              clk,
  input  wire              rst,
  demux32_1x2_reg_if.slave bus
`ifdef DEMUX32_STATS_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  localparam int c_NUM_SLOTS = 2;

  logic [DATA_WIDTH-1:0]  r_data [c_NUM_SLOTS];
  logic [c_NUM_SLOTS-1:0] r_vld;

  logic [c_NUM_SLOTS-1:0] w_take;
  logic [c_NUM_SLOTS-1:0] w_slot_ready;
  logic [c_NUM_SLOTS-1:0] w_drain;
  logic [c_NUM_SLOTS-1:0] w_acc;
  logic [c_NUM_SLOTS-1:0] w_sel;
  logic                   w_in_ready;

  assign w_take       = {bus.y1_ready, bus.y0_ready};
  // A full slot can still take a word when its consumer drains it this cycle.
  assign w_slot_ready = ~r_vld | w_take;
  assign w_in_ready   = w_slot_ready[bus.s];
  assign w_drain      = r_vld & w_take;
  assign w_sel        = {bus.s, ~bus.s};
  assign w_acc        = w_sel & {c_NUM_SLOTS{bus.in_valid & w_in_ready}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < c_NUM_SLOTS; n++) begin
        r_data[n] <= '0;
        r_vld[n]  <= 1'b0;
      end
    end else begin
      for (int n = 0; n < c_NUM_SLOTS; n++) begin
        if (w_acc[n]) begin
          r_data[n] <= bus.i;
          r_vld[n]  <= 1'b1;
        end else if (w_drain[n]) begin
          r_vld[n]  <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.y0       = r_data[0];
  assign bus.y1       = r_data[1];
  assign bus.y0_valid = r_vld[0];
  assign bus.y1_valid = r_vld[1];

`ifdef DEMUX32_STATS_EN
  logic [15:0] r_cnt [c_NUM_SLOTS];

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < c_NUM_SLOTS; n++) begin
        r_cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < c_NUM_SLOTS; n++) begin
        if (w_drain[n]) begin
          r_cnt[n] <= r_cnt[n] + 16'd1;
        end
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux32_1x2_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux32_1x2_reg
// Purpose  : Scoreboard bench for demux32_1x2_reg (directed + random traffic).
// Revision : 1.0  initial release
// ============================================================================
module tb_demux32_1x2_reg;

  logic clk;
  logic rst;
  logic armed;
  int   n_cmp;
  int   n_err;

  // Model: each port is a capacity-one FIFO of accepted, undelivered words.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          mc0;
  int          mc1;

  demux32_1x2_reg_if #(.DATA_WIDTH(32)) bus ();

`ifdef DEMUX32_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  demux32_1x2_reg #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DEMUX32_STATS_EN
    ,
    .cnt0 (cnt0),
    .cnt1 (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: runs mid-cycle, compares outputs to the model and retires
  // words that the consumer takes at the coming edge.
  always @(negedge clk) begin
    if (armed) begin
      check("y0_valid", {31'd0, bus.y0_valid}, {31'd0, q0.size() > 0});
      check("y1_valid", {31'd0, bus.y1_valid}, {31'd0, q1.size() > 0});
      if (q0.size() > 0) check("y0_data", bus.y0, q0[0]);
      if (q1.size() > 0) check("y1_data", bus.y1, q1[0]);
`ifdef DEMUX32_STATS_EN
      check("cnt0", {16'd0, cnt0}, mc0 & 32'hFFFF);
      check("cnt1", {16'd0, cnt1}, mc1 & 32'hFFFF);
`endif
      if (q0.size() > 0 && bus.y0_ready) begin
        void'(q0.pop_front());
        mc0++;
      end
      if (q1.size() > 0 && bus.y1_ready) begin
        void'(q1.pop_front());
        mc1++;
      end
    end
  end

  // One clock of stimulus; after the monitor has retired this cycle's
  // deliveries, a port is ready exactly when its model FIFO is empty.
  task automatic step(input logic r, input logic iv, input logic sel,
                      input logic [31:0] d, input logic r0, input logic r1);
    logic want_ready;
    @(posedge clk);
    #1;
    rst          = r;
    bus.in_valid = iv;
    bus.s        = sel;
    bus.i        = d;
    bus.y0_ready = r0;
    bus.y1_ready = r1;
    @(negedge clk);
    #1;
    if (r) begin
      q0.delete();
      q1.delete();
      mc0 = 0;
      mc1 = 0;
    end else begin
      want_ready = sel ? (q1.size() == 0) : (q0.size() == 0);
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, want_ready});
      if (iv && want_ready) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
      end
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    armed        = 1'b0;
    n_cmp        = 0;
    n_err        = 0;
    mc0          = 0;
    mc1          = 0;
    bus.in_valid = 1'b1;
    bus.s        = 1'b0;
    bus.i        = 32'h12345678;
    bus.y0_ready = 1'b0;
    bus.y1_ready = 1'b0;

    // Reset held with a valid input pending: nothing may be captured.
    step(1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    check("reset_y0", bus.y0, 32'h0);
    check("reset_y1", bus.y1, 32'h0);
    check("reset_v0", {31'd0, bus.y0_valid}, 32'd0);
    check("reset_v1", {31'd0, bus.y1_valid}, 32'd0);
    armed = 1'b1;

    // Routing to each port.
    step(1'b0, 1'b1, 1'b0, 32'h00001234, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000abcd, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("route_y0", bus.y0, 32'h00001234);
    check("route_y1", bus.y1, 32'h0000abcd);

    // Backpressure on Y0; Y1 emptied first, then the word is redirected.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'habcd0000, 1'b0, 1'b0);
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp_y0_hold", bus.y0, 32'h00001234);
    step(1'b0, 1'b1, 1'b1, 32'habcd0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("bp_y1", bus.y1, 32'habcd0000);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Streaming at one word per cycle on port 0.
    step(1'b0, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0);
    check("stream_y0_1", bus.y0, 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
    check("stream_y0_2", bus.y0, 32'h2);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("stream_y0_3", bus.y0, 32'h3);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Mid-operation reset discards both held words.
    step(1'b0, 1'b1, 1'b0, 32'h00ef1200, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h11120000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("midrst_v0", {31'd0, bus.y0_valid}, 32'd0);
    check("midrst_v1", {31'd0, bus.y1_valid}, 32'd0);
    check("midrst_y0", bus.y0, 32'h0);

    // Random traffic with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 64) == 0, $urandom % 2, $urandom % 2, $urandom,
           ($urandom % 3) != 0, ($urandom % 3) == 0);
    end

`ifdef DEMUX32_STATS_EN
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 65536; k++) begin
      step(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_cnt1", {16'd0, cnt1}, 32'd0);
    check("wrap_cnt0", {16'd0, cnt0}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("three_cnt0", {16'd0, cnt0}, 32'd3);
    check("three_cnt1", {16'd0, cnt1}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
